// File: rtl/reg_op_pkg.sv
// reg_op_pkg: shared widths, opcodes and FSM states for the register-op sequencer
package reg_op_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int OP_W       = 3;
    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_NOT = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL = 3'd6;
    localparam logic [OP_W-1:0] OP_SHR = 3'd7;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_EXEC,
        ST_WRITE
    } state_t;
endpackage

// File: rtl/reg_op_alu.sv
// reg_op_alu: combinational ALU producing result/carry/zero from two operands.
// Ports: opcode (operation select), op_a/op_b (operands), result, carry, zero.
// Optional: REG_OP_SEQUENCER_SAT_EN makes ADD saturate high and SUB saturate at 0.
module reg_op_alu
    import reg_op_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);
    // One extra bit on top holds carry, borrow or the shifted-out bit.
    logic [DATA_W:0] wide;
    always_comb begin
        wide = '0;
        case (opcode)
            OP_ADD:  wide = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB:  wide = {1'b0, op_a} - {1'b0, op_b};
            OP_AND:  wide = {1'b0, op_a & op_b};
            OP_OR:   wide = {1'b0, op_a | op_b};
            OP_XOR:  wide = {1'b0, op_a ^ op_b};
            OP_NOT:  wide = {1'b0, ~op_a};
            OP_SHL:  wide = {op_a, 1'b0};
            OP_SHR:  wide = {op_a[0], 1'b0, op_a[DATA_W-1:1]};
            default: wide = '0;
        endcase
    end
`ifdef REG_OP_SEQUENCER_SAT_EN
    assign result = (opcode == OP_ADD && wide[DATA_W]) ? '1 :
                    (opcode == OP_SUB && wide[DATA_W]) ? '0 : wide[DATA_W-1:0];
`else
    assign result = wide[DATA_W-1:0];
`endif
    assign carry = wide[DATA_W];
    assign zero  = result == '0;
endmodule

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: reads two registers, runs the ALU and writes the result back.
// Ports: clock/reset_n; start, opcode, src_a, src_b, dst (command in);
// busy, done, result, carry, zero (status out); rf_load/rf_load_addr,
// rf_store/rf_store_addr/rf_data_in drive the register unit, rf_data_out
// returns its registered read data (1-cycle latency).
// Optional: REG_OP_SEQUENCER_SAT_EN (saturating ADD/SUB inside reg_op_alu).
module reg_op_sequencer
    import reg_op_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [OP_W-1:0]   opcode,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              rf_load,
    output logic [ADDR_W-1:0] rf_load_addr,
    output logic              rf_store,
    output logic [ADDR_W-1:0] rf_store_addr,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out
);
    state_t              state_q, state_d;
    logic [OP_W-1:0]     opcode_q;
    logic [ADDR_W-1:0]   src_a_q, src_b_q, dst_q;
    logic [DATA_W-1:0]   op_a_q, result_q, alu_result;
    logic                carry_q, zero_q, alu_carry, alu_zero;
    logic                accept;
    assign accept = state_q == ST_IDLE && start;
    // In EXEC the register unit still presents src_b's data, so it is op_b directly.
    reg_op_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode (opcode_q),
        .op_a   (op_a_q),
        .op_b   (rf_data_out),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );
    always_comb begin
        state_d       = state_q;
        rf_load       = 1'b0;
        rf_load_addr  = '0;
        rf_store      = 1'b0;
        rf_store_addr = '0;
        done          = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_RD_A : ST_IDLE;
            ST_RD_A: begin
                state_d      = ST_RD_B;
                rf_load      = 1'b1;
                rf_load_addr = src_a_q;
            end
            ST_RD_B: begin
                state_d      = ST_EXEC;
                rf_load      = 1'b1;
                rf_load_addr = src_b_q;
            end
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: begin
                state_d       = ST_IDLE;
                rf_store      = 1'b1;
                rf_store_addr = dst_q;
                done          = 1'b1;
            end
            default:  state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            op_a_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opcode_q <= opcode;
                src_a_q  <= src_a;
                src_b_q  <= src_b;
                dst_q    <= dst;
            end
            // src_a's data arrives one cycle after its RD_A request.
            if (state_q == ST_RD_B)
                op_a_q <= rf_data_out;
            if (state_q == ST_EXEC) begin
                result_q <= alu_result;
                carry_q  <= alu_carry;
                zero_q   <= alu_zero;
            end
        end
    end
    assign busy       = state_q != ST_IDLE;
    assign result     = result_q;
    assign carry      = carry_q;
    assign zero       = zero_q;
    assign rf_data_in = result_q;
endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb_reg_op_sequencer: directed checks of reg_op_sequencer against a 16x8 register unit model
module tb_reg_op_sequencer;
    import reg_op_pkg::*;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [2:0] opcode;
    logic [3:0] src_a, src_b, dst;
    logic       busy, done, carry, zero;
    logic [7:0] result;
    logic       rf_load, rf_store;
    logic [3:0] rf_load_addr, rf_store_addr;
    logic [7:0] rf_data_in, rf_data_out;
    logic [7:0] mem [16];
    logic       pk_en = 1'b0;
    logic [3:0] pk_addr = '0;
    logic [7:0] pk_data = '0;
    int n_chk = 0, n_bad = 0, n_coll = 0, n_st = 0;
    always #5 clk = ~clk;
    reg_op_sequencer dut (
        .clock         (clk),
        .reset_n       (reset_n),
        .start         (start),
        .opcode        (opcode),
        .src_a         (src_a),
        .src_b         (src_b),
        .dst           (dst),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .carry         (carry),
        .zero          (zero),
        .rf_load       (rf_load),
        .rf_load_addr  (rf_load_addr),
        .rf_store      (rf_store),
        .rf_store_addr (rf_store_addr),
        .rf_data_in    (rf_data_in),
        .rf_data_out   (rf_data_out)
    );
    // Register unit model: contents survive reset, read data is registered.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rf_data_out <= '0;
        else begin
            if (rf_load)
                rf_data_out <= mem[rf_load_addr];
            if (rf_store)
                mem[rf_store_addr] <= rf_data_in;
            if (pk_en)
                mem[pk_addr] <= pk_data;
        end
    end
    always @(negedge clk) if (rf_load && rf_store) n_coll++;
    always @(posedge clk) if (rf_store) n_st++;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic poke(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        pk_en = 1'b1; pk_addr = a; pk_data = d;
        @(negedge clk);
        pk_en = 1'b0;
    endtask
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] d,
                           input logic [7:0] er, input logic ec, input logic ez);
        int k;
        @(negedge clk);
        start = 1'b1; opcode = op; src_a = a; src_b = b; dst = d;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        k = 1;
        while (!done && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, k, 4);
        check({tag, "_res"}, result, er);
        check({tag, "_carry"}, carry, ec);
        check({tag, "_zero"}, zero, ez);
        check({tag, "_st"}, {rf_store, rf_store_addr, rf_data_in}, {1'b1, d, er});
        @(negedge clk);
        check({tag, "_mem"}, mem[d], er);
        check({tag, "_idle"}, busy, 0);
    endtask
    initial begin
        int st0, rises, dones, r1, r2;
        logic pb;
        reset_n = 1'b0; start = 1'b0; opcode = '0; src_a = '0; src_b = '0; dst = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {busy, done, rf_load, rf_store, carry, zero}, 0);
        check("rst_data", {result, rf_load_addr, rf_store_addr, rf_data_in}, 0);
        reset_n = 1'b1;
        poke(1, 8'h05); poke(2, 8'h03);
        run_cmd("add", OP_ADD, 1, 2, 3, 8'h08, 0, 0);
        poke(1, 8'hF0); poke(2, 8'h20);
`ifdef REG_OP_SEQUENCER_SAT_EN
        run_cmd("add_c", OP_ADD, 1, 2, 4, 8'hFF, 1, 0);
        run_cmd("sub_b", OP_SUB, 2, 1, 5, 8'h00, 1, 1);
`else
        run_cmd("add_c", OP_ADD, 1, 2, 4, 8'h10, 1, 0);
        run_cmd("sub_b", OP_SUB, 2, 1, 5, 8'h30, 1, 0);
`endif
        run_cmd("xor_self", OP_XOR, 1, 1, 1, 8'h00, 0, 1);
        poke(6, 8'h81);
        run_cmd("shl", OP_SHL, 6, 6, 7, 8'h02, 1, 0);
        run_cmd("shr", OP_SHR, 6, 6, 8, 8'h40, 1, 0);
        poke(9, 8'hCC); poke(10, 8'hAA);
        run_cmd("and", OP_AND, 9, 10, 13, 8'h88, 0, 0);
        run_cmd("or", OP_OR, 9, 10, 14, 8'hEE, 0, 0);
        run_cmd("not", OP_NOT, 9, 10, 15, 8'h33, 0, 0);
        // start held for 10 cycles: accepts at cycles 0 and 5 only
        @(negedge clk);
        start = 1'b1; opcode = OP_ADD; src_a = 9; src_b = 10; dst = 11;
        rises = 0; dones = 0; r1 = -1; r2 = -1; pb = busy;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            if (i == 10) start = 1'b0;
            if (busy && !pb) begin
                rises++;
                if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
            end
            if (done) dones++;
            pb = busy;
        end
        check("hold_accepts", rises, 2);
        check("hold_first", r1, 1);
        check("hold_second", r2, 6);
        check("hold_dones", dones, 2);
`ifdef REG_OP_SEQUENCER_SAT_EN
        check("hold_mem", mem[11], 8'hFF);
`else
        check("hold_mem", mem[11], 8'h76);
`endif
        // reset asserted during EXEC abandons the command
        poke(12, 8'h5A);
        @(negedge clk);
        start = 1'b1; opcode = OP_SUB; src_a = 9; src_b = 10; dst = 12;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("exec_busy", busy, 1);
        st0 = n_st;
        reset_n = 1'b0;
        #1;
        check("mid_rst_ctl", {busy, done, rf_load, rf_store, carry, zero}, 0);
        check("mid_rst_data", {result, rf_load_addr, rf_store_addr, rf_data_in}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_nostore", n_st, st0);
        check("mid_rst_mem", mem[12], 8'h5A);
        run_cmd("post_rst", OP_ADD, 2, 2, 12, 8'h40, 0, 0);
        check("no_collision", n_coll, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
- Sequencer and ALU stage that sits directly in front of the 16x8 register unit and drives its load/store/load_addr/store_addr/data_in ports.
- Consumes its registered data_out.
- Accepts one command (opcode, two source register addresses, one destination address), reads both operands through the single read port, computes the result, and writes it back.
- Provides a start/busy/done handshake to the upstream controller.

Parameters:
- DATA_W, 8, operand/result width; must equal the register unit word size.
- ADDR_W, 4, register address width (16 registers).

Ports:
- clock  in  1  rising-edge clock shared with register unit
- reset_n  in  1  asynchronous active-low reset; the register unit's active-high reset is driven by its inverse at top level
- start  in  1  command valid; sampled only in IDLE
- opcode  in  3  operation select, see Behaviour
- src_a  in  ADDR_W  first operand register
- src_b  in  ADDR_W  second operand register
- dst  in  ADDR_W  destination register
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- done  out  1  one-cycle pulse in WRITE
- result  out  DATA_W  last computed value; held until the next WRITE
- carry  out  1  carry/borrow/shifted-out bit of the last op
- zero  out  1  high when the last result is 0
- rf_load  out  1  to register unit load
- rf_load_addr  out  ADDR_W  to register unit load_addr
- rf_store  out  1  to register unit store
- rf_store_addr  out  ADDR_W  to register unit store_addr
- rf_data_in  out  DATA_W  to register unit data_in (equals result)
- rf_data_out  in  DATA_W  from register unit data_out (registered, 1-cycle read latency)

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, rf_load, rf_store=0; all addresses, result, carry, zero=0. Latched command fields cleared.
  - Reset mid-operation abandons the command; no store is issued.
- FSM: IDLE -> RD_A -> RD_B -> EXEC -> WRITE -> IDLE. Fixed 4 cycles per command; start is accepted again in the cycle after WRITE.
- IDLE: when start=1, latch opcode/src_a/src_b/dst and go to RD_A. start while not in IDLE is ignored; no queueing.
- RD_A: rf_load=1, rf_load_addr=src_a.
- RD_B: rf_load=1, rf_load_addr=src_b. Capture rf_data_out into op_a at the clock edge.
- EXEC: rf_load=0. Compute from op_a and rf_data_out (=op_b); register result, carry, zero at the edge.
- WRITE: rf_store=1, rf_store_addr=dst, rf_data_in=result, done=1.
- rf_load and rf_store are never both high; no read/write collision is possible.
- dst may equal src_a or src_b; operands are read before the write.
- Opcodes, computed at DATA_W+1 bits with carry=MSB:
  - 0 ADD: a+b
  - 1 SUB: a-b; carry=1 on borrow (a<b)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT a
  - 6 SHL a by 1; carry=a[MSB]
  - 7 SHR a by 1, logical; carry=a[0]
- carry=0 for opcodes 2-5. zero=(result==0).
- Wrap-around: ADD/SUB results truncate modulo 2^DATA_W unless the optional feature is enabled.

Optional Feature:
- Macro REG_OP_SEQUENCER_SAT_EN.
- Defined: ADD saturates to all-ones on carry; SUB saturates to 0 on borrow. Carry is still reported.
- Undefined: ADD/SUB wrap modulo 2^DATA_W.

Decomposition:
- Package reg_op_pkg holds:
  - opcode localparams (OP_ADD..OP_SHR)
  - FSM state encodings (ST_IDLE, ST_RD_A, ST_RD_B, ST_EXEC, ST_WRITE)
  - DATA_W/ADDR_W defaults
- One natural sub-module: reg_op_alu, combinational.
  - Inputs: op_a, op_b, opcode.
  - Outputs: result, carry, zero.
  - Contains the SAT_EN logic.
- The sequencer instantiates reg_op_alu and owns the FSM and handshake.

Test Plan:
- Preload r1=0x05, r2=0x03; start ADD src_a=1 src_b=2 dst=3 -> done exactly 4 cycles after start; r3=0x08, carry=0, zero=0.
- r1=0xF0, r2=0x20, ADD dst=4 -> r4=0x10, carry=1 (SAT_EN: r4=0xFF). SUB r2-r1 -> r=0x30, carry=1 (SAT_EN: 0x00, zero=1).
- XOR r1 with r1, dst=1 -> r1=0x00, zero=1. Confirms in-place destination uses pre-write operands.
- start held high for 10 cycles -> exactly two commands executed, at accept cycles 0 and 5; start pulses while busy are ignored.
- Assert reset_n=0 during EXEC -> all outputs 0 immediately; no rf_store pulse; the destination register is unchanged; next start runs normally.
- SHL on 0x81 -> 0x02, carry=1. SHR on 0x81 -> 0x40, carry=1. rf_load and rf_store are never high together in any cycle.
